// File: rtl/ram_pipe_if.sv
// ram_pipe_if: read/write port bundle for ram_pipe.
// Optional parity signals (parerr, wrpinv) exist only when RAM_PARITY_EN is defined.
//
// Port semantics: there is no back-pressure on either port. A request
// (rden or wren) is accepted on every rising clk edge where it is high and
// rst is low. The RAM never stalls, so there is no ready signal.
// rdvalid is a one-cycle strobe that marks the cycle in which rddata
// (and parerr) carry the result of one earlier read request. Results come
// back in request order.
interface ram_pipe_if #(
  parameter int WIDTH = 64,
  parameter int SIZE  = 512,
  parameter int LANE  = 8
);
  localparam int NLANES = WIDTH / LANE;
  localparam int ABITS  = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic              rden;
  logic [ABITS-1:0]  rdaddr;
  logic [WIDTH-1:0]  rddata;
  logic              rdvalid;
  logic              wren;
  logic [NLANES-1:0] wrbe;
  logic [ABITS-1:0]  wraddr;
  logic [WIDTH-1:0]  wrdata;
`ifdef RAM_PARITY_EN
  logic              parerr;
  logic [NLANES-1:0] wrpinv;
`endif

  modport master (
    output rden, rdaddr, wren, wrbe, wraddr, wrdata,
`ifdef RAM_PARITY_EN
    output wrpinv,
    input  parerr,
`endif
    input  rddata, rdvalid
  );

  modport slave (
    input  rden, rdaddr, wren, wrbe, wraddr, wrdata,
`ifdef RAM_PARITY_EN
    input  wrpinv,
    output parerr,
`endif
    output rddata, rdvalid
  );
endinterface

// File: rtl/ram_pipe.sv
// ram_pipe: single-clock simple dual-port RAM with byte-lane write enables,
// a read latency of 1 or 2 cycles with a read-valid strobe, and a selectable
// read-during-write policy (0 = old data, 1 = forwarded new lanes).
// Optional feature macro: RAM_PARITY_EN adds one even-parity bit per lane,
// with error injection through wrpinv and a parerr flag on read.
module ram_pipe #(
  parameter int WIDTH    = 64,
  parameter int SIZE     = 512,
  parameter int LANE     = 8,
  parameter int LATENCY  = 1,
  parameter int RDW_MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  ram_pipe_if.slave  bus
);
  localparam int NLANES = WIDTH / LANE;
  localparam int ABITS  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned SIZE_U = SIZE;

  // Reject parameter combinations the datapath cannot implement.
  generate
    if (!(LATENCY == 1 || LATENCY == 2)) begin : g_bad_latency
      $error("ram_pipe: LATENCY must be 1 or 2");
    end
    if (WIDTH % LANE != 0) begin : g_bad_lane
      $error("ram_pipe: WIDTH must be a multiple of LANE");
    end
  endgenerate

  // Storage starts at all zeros and is never touched by reset.
  logic [WIDTH-1:0] mem [SIZE] = '{default: '0};

  logic wr_ok;
  logic rd_ok;
  logic collide;

  // A write commits only out of reset and inside the array.
  assign wr_ok   = !rst && bus.wren && (32'(bus.wraddr) < SIZE_U);
  assign rd_ok   = bus.rden && (32'(bus.rdaddr) < SIZE_U);
  assign collide = rd_ok && wr_ok && (bus.rdaddr == bus.wraddr);

  // Update enabled lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int k = 0; k < NLANES; k++) begin
        if (bus.wrbe[k]) begin
          mem[bus.wraddr][k*LANE +: LANE] <= bus.wrdata[k*LANE +: LANE];
        end
      end
    end
  end

  logic [WIDTH-1:0]  rd_word;
  logic [NLANES-1:0] fwd_mask;

  // Select the read word: stored data, zero when out of range, and written
  // lanes forwarded on a same-address collision in new-data mode.
  always_comb begin
    rd_word  = '0;
    fwd_mask = '0;
    if (rd_ok) begin
      rd_word = mem[bus.rdaddr];
    end
    if (RDW_MODE == 1 && collide) begin
      for (int k = 0; k < NLANES; k++) begin
        if (bus.wrbe[k]) begin
          rd_word[k*LANE +: LANE] = bus.wrdata[k*LANE +: LANE];
          fwd_mask[k]             = 1'b1;
        end
      end
    end
  end

  logic [WIDTH-1:0] s1_data;
  logic             s1_valid;
  logic             s1_perr;

`ifdef RAM_PARITY_EN
  logic [NLANES-1:0] par_mem [SIZE] = '{default: '0};
  logic [NLANES-1:0] rd_par;
  logic [NLANES-1:0] s1_par;
  logic [NLANES-1:0] s1_fwd;

  // Store per-lane even parity, optionally inverted to inject errors.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int k = 0; k < NLANES; k++) begin
        if (bus.wrbe[k]) begin
          par_mem[bus.wraddr][k] <= (^bus.wrdata[k*LANE +: LANE]) ^ bus.wrpinv[k];
        end
      end
    end
  end

  // Parity accompanying the read word; forwarded lanes get fresh parity.
  always_comb begin
    rd_par = '0;
    if (rd_ok) begin
      rd_par = par_mem[bus.rdaddr];
    end
    for (int k = 0; k < NLANES; k++) begin
      if (fwd_mask[k]) begin
        rd_par[k] = ^bus.wrdata[k*LANE +: LANE];
      end
    end
  end

  // First read stage: capture word, parity and forward mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_par   <= '0;
      s1_fwd   <= '0;
    end else begin
      s1_valid <= bus.rden;
      if (bus.rden) begin
        s1_data <= rd_word;
        s1_par  <= rd_par;
        s1_fwd  <= fwd_mask;
      end
    end
  end

  // Recompute lane parity; forwarded lanes never flag.
  always_comb begin
    s1_perr = 1'b0;
    for (int k = 0; k < NLANES; k++) begin
      if (!s1_fwd[k] && ((^s1_data[k*LANE +: LANE]) != s1_par[k])) begin
        s1_perr = 1'b1;
      end
    end
  end
`else
  // First read stage: capture the selected word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= bus.rden;
      if (bus.rden) begin
        s1_data <= rd_word;
      end
    end
  end

  assign s1_perr = 1'b0;
`endif

  generate
    if (LATENCY == 2) begin : g_lat2
      logic [WIDTH-1:0] s2_data;
      logic             s2_valid;
      logic             s2_perr;

      // Second read stage: extra output register, loaded only by a completing read.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
          s2_perr  <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          s2_perr  <= s1_valid & s1_perr;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign bus.rddata  = s2_data;
      assign bus.rdvalid = s2_valid;
`ifdef RAM_PARITY_EN
      assign bus.parerr  = s2_perr;
`endif
    end else begin : g_lat1
      assign bus.rddata  = s1_data;
      assign bus.rdvalid = s1_valid;
`ifdef RAM_PARITY_EN
      assign bus.parerr  = s1_valid & s1_perr;
`endif
    end
  endgenerate

endmodule
